datapath_result_viewer: RTL

- Downstream consumer of the Regfile/ALU datapath's 16-bit result bus. It sits between the datapath and the board I/O.
- Captures each result the controlling FSM flags as valid into a small on-chip buffer, in write order.
- The user steps through captured entries with a push button. The selected entry is shown as four hex digits on active-low seven-segment displays, and its index on LEDs.

---
 rtl/datapath_result_viewer_pkg.sv | 33 +++
 rtl/button_debouncer.sv | 48 ++++
 rtl/datapath_result_viewer.sv | 116 +++++++++++
 3 files changed

// File: rtl/datapath_result_viewer_pkg.sv
// Shared constants and the seven-segment encoding used by the datapath result viewer.
package datapath_result_viewer_pkg;

    localparam int unsigned DEPTH_DEFAULT  = 16;
    localparam int unsigned ADDR_W_DEFAULT = 4;

    // Segments are {g,f,e,d,c,b,a}, active-low; dash lights only g.
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces an active-low push button; emits a one-cycle pulse on press.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press_pulse
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_n};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign level       = level_q;
    // Pulse coincides with the edge that commits the 1->0 level change.
    assign press_pulse = level_q & ~level_d;

endmodule

// File: rtl/datapath_result_viewer.sv
// Captures flagged datapath results into a buffer and shows a button-selected entry
// as four hex digits plus its index.
module datapath_result_viewer
    import datapath_result_viewer_pkg::*;
#(
    parameter int unsigned DEPTH           = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W          = ADDR_W_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       result,
    input  logic              result_valid,
    input  logic              clear,
    input  logic              step_btn_n,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [ADDR_W-1:0] index_leds,
    output logic              full,
    output logic              overflow
);

    logic [15:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] view_ptr_q, view_ptr_d;
    logic              overflow_q, overflow_d;
    logic [3:0][6:0]   hex_q, hex_d;
    logic [ADDR_W-1:0] index_q;
    logic              wr_en;
    logic              step_pulse;
    logic              unused_btn_level;
    logic [15:0]       sel;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (step_btn_n),
        .level      (unused_btn_level),
        .press_pulse(step_pulse)
    );

    assign full = (count_q == (ADDR_W + 1)'(DEPTH));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        view_ptr_d = view_ptr_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        if (clear) begin
            wr_ptr_d   = '0;
            count_d    = '0;
            view_ptr_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (result_valid) begin
                if (!full) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            // Wrap over captured entries only, judged on the pre-update count.
            if (step_pulse && (count_q != '0)) begin
                view_ptr_d = (view_ptr_q == ADDR_W'(count_q - 1'b1)) ? '0 : view_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    assign sel = mem_q[view_ptr_q];

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            hex_d[n] = (count_q == '0) ? SEG_DASH : hex_to_seg(sel[4*n +: 4]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            view_ptr_q <= '0;
            overflow_q <= 1'b0;
            hex_q      <= {4{SEG_DASH}};
            index_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            view_ptr_q <= view_ptr_d;
            overflow_q <= overflow_d;
            hex_q      <= hex_d;
            index_q    <= view_ptr_q;
        end
    end

    assign hex0       = hex_q[0];
    assign hex1       = hex_q[1];
    assign hex2       = hex_q[2];
    assign hex3       = hex_q[3];
    assign index_leds = index_q;
    assign overflow   = overflow_q;

endmodule
